// File: rtl/router_output_channel.sv
// -----------------------------------------------------------------------------
// router_output_channel
//
// Output-side buffer of a mesh router port. Crossbar traffic is written into
// virtual channel VC[polarity], while VC[~polarity] is drained onto the link
// toward the neighbouring router whenever the downstream channel is ready.
// Because the two sides always target different VCs, each FIFO sees at most
// one operation (push or pop) per cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   polarity   in   0: write VC0 / drain VC1, 1: write VC1 / drain VC0
//   in_valid   in   crossbar presents a flit
//   data_in    in   flit from crossbar
//   in_ready   out  VC[polarity] not full (combinational)
//   out_ready  in   downstream ready; permission to send next cycle
//   out_send   out  registered; out_data carries a valid flit
//   out_data   out  registered link data, zero when out_send=0
//   vc0_count  out  VC0 occupancy
//   vc1_count  out  VC1 occupancy
//   drop_err   out  sticky; a flit was offered while in_ready=0
// -----------------------------------------------------------------------------
module router_output_channel #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_send,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  vc0_count,
    output logic [CNT_W-1:0]  vc1_count,
    output logic              drop_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q  [2][DEPTH];
    logic [PTR_W-1:0]  wptr_q [2];
    logic [PTR_W-1:0]  wptr_d [2];
    logic [PTR_W-1:0]  rptr_q [2];
    logic [PTR_W-1:0]  rptr_d [2];
    logic [CNT_W-1:0]  cnt_q  [2];
    logic [CNT_W-1:0]  cnt_d  [2];

    logic              send_q, send_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              drop_q, drop_d;

    logic wr_vc;
    logic rd_vc;
    logic push;
    logic pop;

    assign wr_vc    = polarity;
    assign rd_vc    = ~polarity;
    assign in_ready = (cnt_q[wr_vc] != CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = out_ready & (cnt_q[rd_vc] != '0);

    // Pointers are PTR_W bits wide, so DEPTH being a power of two makes the
    // increment wrap modulo DEPTH for free.
    always_comb begin
        for (int v = 0; v < 2; v++) begin
            wptr_d[v] = wptr_q[v];
            rptr_d[v] = rptr_q[v];
            cnt_d[v]  = cnt_q[v];
            if (push && (wr_vc == 1'(v))) begin
                wptr_d[v] = wptr_q[v] + PTR_W'(1);
                cnt_d[v]  = cnt_q[v] + CNT_W'(1);
            end
            if (pop && (rd_vc == 1'(v))) begin
                rptr_d[v] = rptr_q[v] + PTR_W'(1);
                cnt_d[v]  = cnt_q[v] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        send_d = pop;
        data_d = pop ? mem_q[rd_vc][rptr_q[rd_vc]] : '0;
        drop_d = drop_q | (in_valid & ~in_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                wptr_q[v] <= '0;
                rptr_q[v] <= '0;
                cnt_q[v]  <= '0;
            end
            send_q <= 1'b0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                wptr_q[v] <= wptr_d[v];
                rptr_q[v] <= rptr_d[v];
                cnt_q[v]  <= cnt_d[v];
            end
            send_q <= send_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    // Flit storage is never reset; occupancy counts alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_vc][wptr_q[wr_vc]] <= data_in;
        end
    end

    assign out_send  = send_q;
    assign out_data  = data_q;
    assign vc0_count = cnt_q[0];
    assign vc1_count = cnt_q[1];
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_router_output_channel.sv
module tb_router_output_channel;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              polarity;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              in_ready;
    logic              out_ready;
    logic              out_send;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  vc0_count;
    logic [CNT_W-1:0]  vc1_count;
    logic              drop_err;

    int checks   = 0;
    int failures = 0;

    router_output_channel #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_send  (out_send),
        .out_data  (out_data),
        .vc0_count (vc0_count),
        .vc1_count (vc1_count),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              pol;
        logic              iv;
        logic [DATA_W-1:0] din;
        logic              ordy;
        logic              irdy;
        logic              send;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  c0;
        logic [CNT_W-1:0]  c1;
        logic              drop;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic irdy, input logic send,
                             input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] c0,
                             input logic [CNT_W-1:0] c1, input logic drop);
        chk({tag, ".in_ready"},  DATA_W'(in_ready),  DATA_W'(irdy));
        chk({tag, ".out_send"},  DATA_W'(out_send),  DATA_W'(send));
        chk({tag, ".out_data"},  out_data,           data);
        chk({tag, ".vc0_count"}, DATA_W'(vc0_count), DATA_W'(c0));
        chk({tag, ".vc1_count"}, DATA_W'(vc1_count), DATA_W'(c1));
        chk({tag, ".drop_err"},  DATA_W'(drop_err),  DATA_W'(drop));
    endtask

    task automatic drive(input logic pol, input logic iv, input logic [DATA_W-1:0] din, input logic ordy);
        polarity  = pol;
        in_valid  = iv;
        data_in   = din;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            pol  iv   din    ordy  irdy send data   c0 c1 drop
        // test 1: single flit across a polarity toggle
        vec[0]  = '{1'b0, 1'b1, 64'hA1, 1'b1, 1'b1, 1'b0, 64'h0,  2'd1, 2'd0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA1, 2'd0, 2'd0, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  2'd0, 2'd0, 1'b0};
        // test 2: fill VC0, third push dropped
        vec[3]  = '{1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 1'b0, 64'h0,  2'd1, 2'd0, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 64'h0,  2'd2, 2'd0, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 64'h0,  2'd2, 2'd0, 1'b1};
        // preload VC1 while draining VC0
        vec[6]  = '{1'b1, 1'b1, 64'hB1, 1'b1, 1'b1, 1'b1, 64'h11, 2'd1, 2'd1, 1'b1};
        vec[7]  = '{1'b1, 1'b1, 64'hB2, 1'b1, 1'b0, 1'b1, 64'h22, 2'd0, 2'd2, 1'b1};
        // test 3: back-to-back drain of VC1 while VC0 fills
        vec[8]  = '{1'b0, 1'b1, 64'hC1, 1'b1, 1'b1, 1'b1, 64'hB1, 2'd1, 2'd1, 1'b1};
        vec[9]  = '{1'b0, 1'b1, 64'hC2, 1'b1, 1'b0, 1'b1, 64'hB2, 2'd2, 2'd0, 1'b1};
        vec[10] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 64'h0,  2'd2, 2'd0, 1'b1};
        vec[11] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hC1, 2'd1, 2'd0, 1'b1};
        vec[12] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hC2, 2'd0, 2'd0, 1'b1};
        // test 5: ping-pong round trips through wrapping pointers
        vec[13] = '{1'b0, 1'b1, 64'h1,  1'b1, 1'b1, 1'b0, 64'h0,  2'd1, 2'd0, 1'b1};
        vec[14] = '{1'b1, 1'b1, 64'h2,  1'b1, 1'b1, 1'b1, 64'h1,  2'd0, 2'd1, 1'b1};
        vec[15] = '{1'b0, 1'b1, 64'h3,  1'b1, 1'b1, 1'b1, 64'h2,  2'd1, 2'd0, 1'b1};
        vec[16] = '{1'b1, 1'b1, 64'h4,  1'b1, 1'b1, 1'b1, 64'h3,  2'd0, 2'd1, 1'b1};
        vec[17] = '{1'b0, 1'b1, 64'h5,  1'b1, 1'b1, 1'b1, 64'h4,  2'd1, 2'd0, 1'b1};
        vec[18] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h5,  2'd0, 2'd0, 1'b1};
        // zero-valued flit is real data; out_send marks it
        vec[19] = '{1'b0, 1'b1, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  2'd1, 2'd0, 1'b1};
        vec[20] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h0,  2'd0, 2'd0, 1'b1};

        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        step();
        check_all("reset", 1'b1, 1'b0, '0, '0, '0, 1'b0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].pol, vec[i].iv, vec[i].din, vec[i].ordy);
            step();
            check_all($sformatf("vec%0d", i), vec[i].irdy, vec[i].send, vec[i].data,
                      vec[i].c0, vec[i].c1, vec[i].drop);
        end

        // test 4: drain stall with out_ready 1,0,1
        drive(1'b1, 1'b1, 64'hD1, 1'b0);
        step();
        drive(1'b1, 1'b1, 64'hD2, 1'b0);
        step();
        check_all("stall_pre", 1'b0, 1'b0, '0, 2'd0, 2'd2, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        check_all("stall_r1", 1'b1, 1'b1, 64'hD1, 2'd0, 2'd1, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        check_all("stall_r0", 1'b1, 1'b0, 64'h0, 2'd0, 2'd1, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        check_all("stall_r2", 1'b1, 1'b1, 64'hD2, 2'd0, 2'd0, 1'b1);
        step();
        check_all("stall_idle", 1'b1, 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);

        // test 6: asynchronous reset with both VCs occupied and a flit on the link
        drive(1'b0, 1'b1, 64'hE1, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'hE2, 1'b0);
        step();
        drive(1'b1, 1'b1, 64'hE3, 1'b1);
        step();
        check_all("pre_reset", 1'b1, 1'b1, 64'hE1, 2'd1, 2'd1, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_all("async_reset", 1'b1, 1'b0, '0, 2'd0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 64'hF1, 1'b1);
        #2;
        reset = 1'b1;
        step();
        check_all("post_reset", 1'b1, 1'b0, '0, 2'd1, 2'd0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b1);
        step();
        check_all("post_reset_drain", 1'b1, 1'b1, 64'hF1, 2'd0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
